// File: rtl/tick_pkg.sv
// Shared types and default constants for the run-controlled tick enable generator.
package tick_pkg;

    // Run-control states: stopped, counting, and paused with the prescaler phase kept.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } tick_state_t;

    // A 10 Hz strobe from the 50 MHz system clock.
    localparam int unsigned TICK_PERIOD_10HZ   = 5_000_000;

    // 10 ms of contact-bounce rejection at 50 MHz.
    localparam int unsigned TICK_DEBOUNCE_10MS = 500_000;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, debouncer that accepts a new
// level only after it has been stable long enough, and a rising-edge press pulse.
module button_debounce
    import tick_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = TICK_DEBOUNCE_10MS
) (
    input  logic CLK_50M,
    input  logic RESET_N,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] stable_cnt;
    logic             level_prev;

    // Bring the asynchronous button onto CLK_50M through two flops.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // Count consecutive cycles of disagreement; any agreeing cycle starts over.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_q != level) begin
            if (stable_cnt == CNT_LAST) begin
                level      <= sync_q;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    // One-cycle press on a debounced rising edge; releases are ignored.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            level_prev <= 1'b0;
            press      <= 1'b0;
        end else begin
            level_prev <= level;
            press      <= level & ~level_prev;
        end
    end

endmodule

// File: rtl/tick_enable_gen.sv
// Run-controlled clock-enable generator: produces a one-cycle 'active' strobe every
// 'period' CLK_50M cycles while running, under control of run/pause and clear buttons.
module tick_enable_gen
    import tick_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH    = 30,
    parameter int unsigned DEBOUNCE_CYCLES = TICK_DEBOUNCE_10MS
) (
    input  logic                    CLK_50M,
    input  logic                    RESET_N,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    btn_run,
    input  logic                    btn_clear,
    output logic                    active,
    output logic                    running,
    output logic                    clear
);

    tick_state_t             state;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] cnt_last;
    logic                    run_press;
    logic                    clear_press;
    logic                    run_level;
    logic                    clear_level;
    logic                    unused_levels;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_btn (
        .CLK_50M(CLK_50M),
        .RESET_N(RESET_N),
        .btn_raw(btn_run),
        .level  (run_level),
        .press  (run_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_btn (
        .CLK_50M(CLK_50M),
        .RESET_N(RESET_N),
        .btn_raw(btn_clear),
        .level  (clear_level),
        .press  (clear_press)
    );

    // Only the press pulses steer this block; the held levels are not needed here.
    assign unused_levels = run_level & clear_level;

    // Terminal count for the current period, with a period of 0 behaving like 1.
    assign cnt_last = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);

    // Run/pause/clear state machine; clear beats a simultaneous run press.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            running <= 1'b0;
            clear   <= 1'b0;
        end else begin
            clear <= clear_press;
            if (clear_press) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (run_press) begin
                case (state)
                    IDLE, HOLD: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= HOLD;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Prescaler: counts in RUN, freezes in HOLD to keep phase, and parks at 0 in IDLE.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            active <= 1'b0;
            case (state)
                RUN: begin
                    if (cnt >= cnt_last) begin
                        active <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + PERIOD_WIDTH'(1);
                    end
                end
                HOLD:    cnt <= cnt;
                default: cnt <= '0;
            endcase
        end
    end

endmodule
